// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and bit-order constants for the PISO serializer family
package piso_pkg;
  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_SHIFT  = 2'd1;
  localparam logic [1:0] STATE_PARITY = 2'd2;
  typedef enum logic [1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_SHIFT  = STATE_SHIFT,
    ST_PARITY = STATE_PARITY
  } piso_state_t;
  localparam logic ORDER_LSB_FIRST = 1'b0;
  localparam logic ORDER_MSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable falling-edge down-counter with enable and an is_one flag
module piso_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);
  // load wins over decrement; enable at zero holds rather than wrapping
  always_ff @(negedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (load) count <= load_value;
    else if (enable && count != '0) count <= count - WIDTH'(1);
  end
  assign is_one = count == WIDTH'(1);
endmodule

// File: rtl/piso_serializer_param.sv
// piso_serializer_param: parametrised PISO serializer with load handshake, strobe gating and back-to-back frames; PISO_PARITY_EN appends an even-parity bit
module piso_serializer_param
  import piso_pkg::*;
#(
  parameter int   DATA_WIDTH  = 16,
  parameter logic IDLE_LEVEL  = 1'b0,
  localparam int  COUNT_WIDTH = $clog2(DATA_WIDTH + 2)
) (
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  input  logic                   Load_Valid_In,
  output logic                   Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0]  Parallel_Data_In,
  input  logic                   Msb_First_In,
  input  logic                   Shift_Enable_In,
  output logic                   Serial_Data_Out,
  output logic                   Serial_Valid_Out,
  output logic                   Frame_Last_Out,
  output logic                   Busy_Out,
  output logic [COUNT_WIDTH-1:0] Bits_Remaining_Out,
  output logic [DATA_WIDTH-1:0]  Shift_Register_Out
);
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("piso_serializer_param: DATA_WIDTH must be >= 2");
  end
  piso_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q;
  logic                  order_q;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                  cnt_is_one, in_shift, in_par, par_bit, last_bit, accept;
  assign in_shift = state_q == ST_SHIFT;
`ifdef PISO_PARITY_EN
  localparam piso_state_t            END_STATE = ST_PARITY;
  localparam logic [COUNT_WIDTH-1:0] TAIL_BITS = COUNT_WIDTH'(1);
  logic parity_q;
  assign in_par   = state_q == ST_PARITY;
  assign par_bit  = parity_q;
  assign last_bit = in_par;
  // parity of the whole word is captured once, at load
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) parity_q <= 1'b0;
    else if (accept) parity_q <= ^Parallel_Data_In;
  end
`else
  localparam piso_state_t            END_STATE = ST_IDLE;
  localparam logic [COUNT_WIDTH-1:0] TAIL_BITS = '0;
  assign in_par   = 1'b0;
  assign par_bit  = 1'b0;
  assign last_bit = in_shift && cnt_is_one;
`endif
  assign Load_Ready_Out = state_q == ST_IDLE || (last_bit && Shift_Enable_In);
  assign accept         = Load_Valid_In && Load_Ready_Out;
  piso_bit_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
    .clk       (Clk_In),
    .rst       (Reset_In),
    .load      (accept),
    .enable    (in_shift && Shift_Enable_In),
    .load_value(COUNT_WIDTH'(DATA_WIDTH)),
    .count     (cnt),
    .is_one    (cnt_is_one)
  );
  // state register
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // next state: a load always restarts SHIFT, otherwise the final strobed bit leaves the frame
  always_comb begin
    state_d = accept ? ST_SHIFT
            : (in_shift && Shift_Enable_In && cnt_is_one) ? END_STATE
            : (in_par && Shift_Enable_In) ? ST_IDLE
            : state_q;
  end
  // shift datapath: the register empties on the last data bit so idle always reads zero
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      sr_q    <= '0;
      order_q <= ORDER_LSB_FIRST;
    end else if (accept) begin
      sr_q    <= Parallel_Data_In;
      order_q <= Msb_First_In;
    end else if (in_shift && Shift_Enable_In) begin
      sr_q <= cnt_is_one ? '0 : (order_q == ORDER_MSB_FIRST) ? sr_q << 1 : sr_q >> 1;
    end
  end
  // outputs decoded from state and the head of the shift register
  always_comb begin
    Serial_Valid_Out   = in_shift || in_par;
    Serial_Data_Out    = in_shift ? ((order_q == ORDER_MSB_FIRST) ? sr_q[DATA_WIDTH-1] : sr_q[0])
                       : in_par ? par_bit : IDLE_LEVEL;
    Frame_Last_Out     = last_bit;
    Busy_Out           = state_q != ST_IDLE;
    Bits_Remaining_Out = in_shift ? cnt + TAIL_BITS : in_par ? COUNT_WIDTH'(1) : '0;
  end
  assign Shift_Register_Out = sr_q;
endmodule

// File: doc/piso_serializer_param.md
Name: piso_serializer_param

Overview:
Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, per-frame bit-order select, bit-strobe gating and back-to-back framing.
- Next-generation replacement for the fixed-width PISO shift registers.
- Feeds bit-serial links, e.g. SPI/UART-style transmit paths, from a word-wide source.
- Bit-rate pacing comes from an external strobe, so one block serves any baud divider.

Parameters:
DATA_WIDTH, 16, serialized word width; must be >= 2, otherwise elaboration error.
IDLE_LEVEL, 1'b0, level driven on Serial_Data_Out when no frame is active.
COUNT_WIDTH, $clog2(DATA_WIDTH+2), localparam, width of the bit counter; not user-overridable.

Ports:
Clk_In  input  1  single clock; all state updates on falling edge.
Reset_In  input  1  asynchronous, active-high reset.
Load_Valid_In  input  1  source presents a word.
Load_Ready_Out  output  1  block can accept a word this edge.
Parallel_Data_In  input  DATA_WIDTH  word to serialize.
Msb_First_In  input  1  bit order for this word (1 = MSB first); sampled only at load.
Shift_Enable_In  input  1  bit strobe; one bit is consumed per strobed falling edge.
Serial_Data_Out  output  1  current serial bit.
Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit.
Frame_Last_Out  output  1  current bit is the last bit of the frame.
Busy_Out  output  1  frame in progress (state != IDLE).
Bits_Remaining_Out  output  COUNT_WIDTH  bits left, including the current bit.
Shift_Register_Out  output  DATA_WIDTH  internal shift register, for debug.

Behaviour:
Clock and reset (already decided): one clock, Clk_In; Reset_In is asynchronous and active-high.

Reset:
- Asserting Reset_In immediately forces state IDLE, shift register 0, count 0 and stored order 0.
- Outputs under reset: Serial_Data_Out=IDLE_LEVEL; Serial_Valid_Out, Frame_Last_Out and Busy_Out all 0; Load_Ready_Out=1.
- Reset mid-frame aborts the frame with no further bits. The first falling edge after deassertion behaves as IDLE.

States: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).

Load_Ready_Out (combinational):
- 1 in IDLE.
- 1 on the final bit of a frame when Shift_Enable_In=1.
- 0 otherwise.

Load accept:
- A load is accepted on a falling edge when Load_Valid_In && Load_Ready_Out.
- On accept: register <= Parallel_Data_In, count <= DATA_WIDTH, order <= Msb_First_In, state <= SHIFT.
- Zero-latency back-to-back: a word accepted on the final-bit edge makes its first bit valid immediately after that edge, with no idle gap.
- Load_Valid_In while Load_Ready_Out=0 is ignored; no data is sampled.

SHIFT state:
- Serial_Data_Out = order ? reg[DATA_WIDTH-1] : reg[0]; Serial_Valid_Out=1.
- Edge with Shift_Enable_In=1 and count > 1:
  - MSB-first: shift left, zero-fill LSB.
  - LSB-first: shift right, zero-fill MSB.
  - count decrements by 1.
- Edge with Shift_Enable_In=1 and count == 1:
  - Reload if a load is accepted.
  - Otherwise go to PARITY if the feature is enabled, else IDLE; register becomes 0.
- Shift_Enable_In=0: register, count and state all hold.
- Mid-frame changes to Msb_First_In or Parallel_Data_In have no effect.

Other outputs:
- Frame_Last_Out = Serial_Valid_Out && (final bit of frame).
- Bits_Remaining_Out = 0 in IDLE.
- In IDLE, Serial_Data_Out = IDLE_LEVEL.

Optional Feature:
PISO_PARITY_EN
- Defined:
  - At load, the even parity (XOR) of Parallel_Data_In is captured.
  - After the data bits the block enters PARITY and presents the parity bit with Serial_Valid_Out=1, Frame_Last_Out=1 and Bits_Remaining_Out=1.
  - The parity bit is consumed on one strobed edge. Load_Ready_Out and back-to-back reload apply at that edge instead of at the last data bit.
  - In SHIFT the frame is DATA_WIDTH+1 bits, so Bits_Remaining_Out = count+1.
- Undefined: the PARITY state and the parity register are absent, and frames are exactly DATA_WIDTH bits.

Decomposition:
- Package piso_pkg holds:
  - state typedef (IDLE/SHIFT/PARITY) and its encoding localparams;
  - bit-order constants ORDER_LSB_FIRST=0, ORDER_MSB_FIRST=1.
- One natural sub-module, piso_bit_counter: loadable down-counter with enable, load value and an is_one flag. It is shared with future SIPO deserializers.

Test Plan:
1. LSB-first: reset, DATA_WIDTH=16, load 16'hA5C3 with Msb_First_In=0 and strobe every cycle -> serial 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. Frame_Last_Out is high on the 16th bit only, then back to IDLE_LEVEL with Load_Ready_Out=1.
2. MSB-first: same word with Msb_First_In=1 -> serial 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
3. Back-to-back: 16'hA5C3 then 16'h0001 with Load_Valid_In held -> second word accepted on the 16th-bit edge; 32 consecutive valid bits; Busy_Out never drops.
4. Strobe gating: Shift_Enable_In high every 3rd cycle -> each bit held 3 cycles, Bits_Remaining_Out 16->1 on strobes only. A Load_Valid_In pulse at bit 5 is ignored and the frame is unaltered.
5. Reset mid-frame: Reset_In pulse between edges after 5 bits -> outputs at reset values immediately, without waiting for a clock edge. A subsequent load of 16'h8000 (MSB-first) outputs 1 followed by 15 zeros.
6. PISO_PARITY_EN: 16'h0007 -> 16 data bits then parity 1, Frame_Last_Out on the 17th bit; 16'hA5C3 -> parity 0.
